// File: rtl/sum_bcd_pkg.sv
// Shared types and constants for the binary-sum to BCD converter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sum_bcd_pkg;

   // Converter control states
   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Double-dabble digit adjust: a digit at or above 5 would exceed 9 after
   // the next doubling, so it is pre-corrected by +3.
   localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
   localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

   // Active-high segments, bit 6 = g ... bit 0 = a. Entry 10 is blank.
   localparam int SEG_BLANK_IDX = 10;
   localparam logic [10:0][6:0] SEG_TABLE = {
      7'h00,                                        // blank
      7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,            // 9 8 7 6 5
      7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F             // 4 3 2 1 0
   };

   // Non-decimal digit codes render as blank
   function automatic logic [6:0] seg_decode(input logic [3:0] digit);
      if (digit <= 4'd9) begin
         return SEG_TABLE[digit];
      end
      return SEG_TABLE[SEG_BLANK_IDX];
   endfunction

endpackage

// File: rtl/bcd_add3.sv
// One BCD digit adjust stage: adds 3 when the digit is 5 or more.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its input.
module bcd_add3
   import sum_bcd_pkg::*;
(
   input  logic [3:0] din,
   output logic [3:0] dout
);

   assign dout = (din >= BCD_ADJ_THRESH) ? (din + BCD_ADJ_ADD) : din;

endmodule

// File: rtl/sum_bcd_converter.sv
// Converts the adder's binary sum to packed BCD by serial double dabble.
// Latency: done pulses WIDTH clocks after the accepting edge; one result per WIDTH+1 clocks.
// Backpressure: none; start is only sampled in IDLE, requests while busy are dropped.
// Optional build macro SUM_BCD_SEG_EN adds a registered 7-segment output.
module sum_bcd_converter
   import sum_bcd_pkg::*;
#(
   parameter int WIDTH  = 9,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  ovf
`ifdef SUM_BCD_SEG_EN
   ,
   output logic [7*DIGITS-1:0]   seg
`endif
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(1);

   state_t                state;
   state_t                state_nxt;
   logic [WIDTH-1:0]      shreg;
   logic [4*DIGITS-1:0]   scr;
   logic                  ovf_scr;
   logic [CW-1:0]         count;

   logic                  load;
   logic                  shift_en;
   logic                  finish;
   logic [4*DIGITS-1:0]   adj;
   logic [4*DIGITS-1:0]   scr_nxt;
   logic [WIDTH-1:0]      shreg_nxt;
   logic                  out_bit;

   // Per-digit +3 correction applied before every shift
   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_add3 u_add3 (
         .din  (scr[4*g +: 4]),
         .dout (adj[4*g +: 4])
      );
   end

   // The bit leaving the top digit means the value needs more than DIGITS digits
   assign scr_nxt   = {adj[4*DIGITS-2:0], shreg[WIDTH-1]};
   assign shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
   assign out_bit   = adj[4*DIGITS-1];

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and control decode
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      load      = 1'b0;
      shift_en  = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            busy     = 1'b1;
            shift_en = 1'b1;
            if (count == CNT_LAST) begin
               finish    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Scratch datapath and result registers; results only change on the final shift
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shreg   <= '0;
         scr     <= '0;
         ovf_scr <= 1'b0;
         count   <= '0;
         bcd     <= '0;
         ovf     <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= finish;
         if (load) begin
            shreg   <= bin;
            scr     <= '0;
            ovf_scr <= 1'b0;
            count   <= CNT_INIT;
         end else if (shift_en) begin
            shreg   <= shreg_nxt;
            scr     <= scr_nxt;
            ovf_scr <= ovf_scr | out_bit;
            count   <= count - 1'b1;
         end
         if (finish) begin
            bcd <= scr_nxt;
            ovf <= ovf_scr | out_bit;
         end
      end
   end

`ifdef SUM_BCD_SEG_EN
   logic [7*DIGITS-1:0] seg_nxt;

   // Segment decode of the result about to be committed
   always_comb begin
      seg_nxt = '0;
      for (int i = 0; i < DIGITS; i++) begin
         seg_nxt[7*i +: 7] = seg_decode(scr_nxt[4*i +: 4]);
      end
   end

   // Segment register, loaded together with bcd so the two always agree
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         seg <= '0;
      end else if (finish) begin
         seg <= seg_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_sum_bcd_converter.sv
// Scoreboard bench for sum_bcd_converter (3-digit and 2-digit instances).
// Expected results are queued at request time; monitors compare on done.
// Directed vectors cover latency, hold, ignore-while-busy, streaming and reset abort.
module tb_sum_bcd_converter;

   logic        clk    = 1'b0;
   logic        rst    = 1'b0;
   logic        start  = 1'b0;
   logic [8:0]  bin    = '0;
   logic        busy, done, ovf;
   logic [11:0] bcd;

   logic        start2 = 1'b0;
   logic [8:0]  bin2   = '0;
   logic        busy2, done2, ovf2;
   logic [7:0]  bcd2;

`ifdef SUM_BCD_SEG_EN
   logic [20:0] seg;
   logic [13:0] seg2;
`endif

   int total = 0;
   int bad   = 0;

   logic [12:0] exp_q[$];
   logic [8:0]  exp2_q[$];

   always #5 clk = ~clk;

   sum_bcd_converter #(.WIDTH(9), .DIGITS(3)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .bcd   (bcd),
      .ovf   (ovf)
`ifdef SUM_BCD_SEG_EN
      ,
      .seg   (seg)
`endif
   );

   sum_bcd_converter #(.WIDTH(9), .DIGITS(2)) dut2 (
      .clk   (clk),
      .rst   (rst),
      .start (start2),
      .bin   (bin2),
      .busy  (busy2),
      .done  (done2),
      .bcd   (bcd2),
      .ovf   (ovf2)
`ifdef SUM_BCD_SEG_EN
      ,
      .seg   (seg2)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Monitor for the 3-digit instance
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL dut3_extra_done: got bcd=%h ovf=%b, required no done", bcd, ovf);
         end else begin
            check("dut3_result", {19'd0, ovf, bcd}, {19'd0, exp_q.pop_front()});
         end
      end
   end

   // Monitor for the 2-digit instance
   always @(negedge clk) begin
      if (done2 === 1'b1) begin
         if (exp2_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL dut2_extra_done: got bcd=%h ovf=%b, required no done", bcd2, ovf2);
         end else begin
            check("dut2_result", {23'd0, ovf2, bcd2}, {23'd0, exp2_q.pop_front()});
         end
      end
   end

   // One-cycle start request: raised just after an edge, accepted on the next edge
   task automatic pulse(input bit sel, input logic [8:0] v);
      @(posedge clk);
      #1;
      if (sel) begin bin2 = v; start2 = 1'b1; end
      else     begin bin  = v; start  = 1'b1; end
      @(posedge clk);
      #1;
      if (sel) start2 = 1'b0;
      else     start  = 1'b0;
   endtask

   // Waits (bounded) for done; reports busy cycles seen and negedges waited
   task automatic wait_done(input bit sel, output int nbusy, output int nwait);
      bit seen;
      nbusy = 0;
      nwait = 0;
      seen  = 1'b0;
      while (!seen && nwait < 40) begin
         @(negedge clk);
         nwait++;
         if ((sel ? done2 : done) === 1'b1) seen = 1'b1;
         else if ((sel ? busy2 : busy) === 1'b1) nbusy++;
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL done_timeout: got no done in %0d cycles, required one", nwait);
      end
   endtask

   initial begin
      int nb, nw;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_bcd",  {20'd0, bcd},  32'd0);
      check("rst_ovf",  {31'd0, ovf},  32'd0);
`ifdef SUM_BCD_SEG_EN
      check("rst_seg",  {11'd0, seg},  32'd0);
`endif
      @(negedge clk);
      rst = 1'b1;

      // 22 -> 022, nine busy cycles, single-cycle done
      exp_q.push_back({1'b0, 12'h022});
      pulse(1'b0, 9'd22);
      wait_done(1'b0, nb, nw);
      check("lat22_busy", nb, 32'd9);
      check("lat22_wait", nw, 32'd10);
`ifdef SUM_BCD_SEG_EN
      check("seg22", {11'd0, seg}, {11'd0, 7'h3F, 7'h5B, 7'h5B});
`endif
      @(negedge clk);
      check("done_one_cycle", {31'd0, done}, 32'd0);

      // 510 then 0; 510 held until the second completion
      exp_q.push_back({1'b0, 12'h510});
      pulse(1'b0, 9'd510);
      wait_done(1'b0, nb, nw);
      exp_q.push_back({1'b0, 12'h000});
      pulse(1'b0, 9'd0);
      repeat (4) @(negedge clk);
      check("hold_510", {20'd0, bcd}, 32'h510);
      wait_done(1'b0, nb, nw);

      // Second request while busy is ignored; bin not resampled
      exp_q.push_back({1'b0, 12'h022});
      pulse(1'b0, 9'd22);
      @(posedge clk);
      @(posedge clk);
      #1;
      bin   = 9'd99;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(1'b0, nb, nw);
      check("ignore_busy", nb, 32'd6);
      check("ignore_wait", nw, 32'd7);
      repeat (12) @(negedge clk);

      // Start held high: a result every WIDTH+1 clocks
      for (int k = 0; k < 3; k++) exp_q.push_back({1'b0, 12'h007});
      @(posedge clk);
      #1;
      bin   = 9'd7;
      start = 1'b1;
      wait_done(1'b0, nb, nw);
      check("stream0_busy", nb, 32'd9);
      for (int k = 1; k < 3; k++) begin
         wait_done(1'b0, nb, nw);
         check("stream_busy", nb, 32'd9);
         check("stream_period", nw, 32'd10);
      end
      start = 1'b0;
      repeat (12) @(negedge clk);

      // Asynchronous reset mid-conversion (count=4)
      pulse(1'b0, 9'd22);
      repeat (5) @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_done", {31'd0, done}, 32'd0);
      check("arst_bcd",  {20'd0, bcd},  32'd0);
      check("arst_ovf",  {31'd0, ovf},  32'd0);
      #2;
      rst = 1'b1;
      repeat (15) @(negedge clk);
      exp_q.push_back({1'b0, 12'h022});
      pulse(1'b0, 9'd22);
      wait_done(1'b0, nb, nw);
      check("post_rst_busy", nb, 32'd9);

      // Two-digit instance: overflow and exact fit
      exp2_q.push_back({1'b1, 8'h55});
      pulse(1'b1, 9'd255);
      wait_done(1'b1, nb, nw);
      check("d2_busy", nb, 32'd9);
      exp2_q.push_back({1'b0, 8'h99});
      pulse(1'b1, 9'd99);
      wait_done(1'b1, nb, nw);

      repeat (5) @(negedge clk);
      check("q3_drained", exp_q.size(), 32'd0);
      check("q2_drained", exp2_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
